// File: rtl/fwd_bypass_net.sv
// ---------------------------------------------------------------------------
// fwd_bypass_net
//   Parametrised forwarding and hazard unit that sits beside the D stage.
//   A scoreboard shift register tracks NSTAGE producer stages
//   (stage 0 = E, stage NSTAGE-1 = W). Each entry holds a destination
//   register, a Tnew countdown and a valid bit. For each of NRD read ports
//   the unit computes the forward select, the corrected operand, a pending
//   flag and a stall request.
//
// Ports
//   clk            clock, rising-edge state updates
//   reset          synchronous active-high, clears scoreboard and counter
//   i_freeze       hold the whole scoreboard (external busy)
//   i_issue_valid  D instruction writes a register
//   i_issue_addr   destination register of the D instruction
//   i_issue_tnew   cycles after entering stage 0 until its result exists
//   i_stage_data   result of stage k at [k*DW +: DW]
//   i_rd_addr      source register per read port
//   i_rd_tuse      cycles until the consumer needs the operand
//   i_rd_val       register-file value per port
//   o_rd_val       corrected operand per port
//   o_rd_sel       0 = no forward, k+1 = forwarded from stage k
//   o_rd_pend      producer matched but its data is not ready yet
//   o_stall        stall D/F, a bubble enters stage 0
//   o_stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_bypass_net #(
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_freeze,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_addr,
  input  logic [TW-1:0]        i_issue_tnew,
  input  logic [NSTAGE*DW-1:0] i_stage_data,
  input  logic [NRD*AW-1:0]    i_rd_addr,
  input  logic [NRD*TW-1:0]    i_rd_tuse,
  input  logic [NRD*DW-1:0]    i_rd_val,
  output logic [NRD*DW-1:0]    o_rd_val,
  output logic [NRD*SW-1:0]    o_rd_sel,
  output logic [NRD-1:0]       o_rd_pend,
  output logic                 o_stall,
  output logic [31:0]          o_stall_cnt
);

  // Countdown that sticks at zero once the result exists.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  // Counter increment that pins at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  logic [NSTAGE-1:0]         v_q, v_d;
  logic [NSTAGE-1:0][AW-1:0] a_q, a_d;
  logic [NSTAGE-1:0][TW-1:0] t_q, t_d;
  logic [31:0]               stall_cnt_q;
  logic [NRD-1:0]            stall_req;

  assign o_stall_cnt = stall_cnt_q;
  assign o_stall     = |stall_req;

  // Next scoreboard contents for an advance edge. Writes to $0 never
  // create a hazard, and an issue blocked by a stall becomes a bubble.
  always_comb begin
    v_d    = '0;
    a_d    = '0;
    t_d    = '0;
    v_d[0] = i_issue_valid && !o_stall && (i_issue_addr != '0);
    a_d[0] = i_issue_addr;
    t_d[0] = i_issue_tnew;
    for (int k = 1; k < NSTAGE; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      t_d[k] = sat_dec(t_q[k-1]);
    end
  end

  // Scoreboard shift register and stall counter; reset wins over freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      a_q         <= '0;
      t_q         <= '0;
      stall_cnt_q <= '0;
    end else if (!i_freeze) begin
      v_q <= v_d;
      a_q <= a_d;
      t_q <= t_d;
      if (o_stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // Per-port lookup: the youngest matching stage wins; older matches are
  // masked by the hit flag so they cannot override it.
  always_comb begin
    logic [AW-1:0] addr;
    logic [TW-1:0] tuse;
    logic          hit;
    o_rd_val  = i_rd_val;
    o_rd_sel  = '0;
    o_rd_pend = '0;
    stall_req = '0;
    for (int r = 0; r < NRD; r++) begin
      addr = i_rd_addr[r*AW +: AW];
      tuse = i_rd_tuse[r*TW +: TW];
      hit  = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!hit && (addr != '0) && v_q[k] && (a_q[k] == addr)) begin
          hit = 1'b1;
          if (t_q[k] == '0) begin
            o_rd_sel[r*SW +: SW] = SW'(k + 1);
            o_rd_val[r*DW +: DW] = i_stage_data[k*DW +: DW];
          end else begin
            // Not ready: a later-stage mux can catch it if it arrives
            // before the consumer needs it, otherwise D must wait.
            o_rd_pend[r] = 1'b1;
            if (t_q[k] > tuse) stall_req[r] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_bypass_net.sv
module tb_fwd_bypass_net;

  localparam int NSTAGE = 3;
  localparam int NRD    = 2;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int TW     = 2;
  localparam int SW     = 2;

  localparam logic [31:0] D0  = 32'h1111_1111;
  localparam logic [31:0] D1  = 32'h2222_2222;
  localparam logic [31:0] D2  = 32'h3333_3333;
  localparam logic [31:0] RV0 = 32'hAAAA_0000;
  localparam logic [31:0] RV1 = 32'hBBBB_0001;

  logic                 clk;
  logic                 reset;
  logic                 i_freeze;
  logic                 i_issue_valid;
  logic [AW-1:0]        i_issue_addr;
  logic [TW-1:0]        i_issue_tnew;
  logic [NSTAGE*DW-1:0] i_stage_data;
  logic [NRD*AW-1:0]    i_rd_addr;
  logic [NRD*TW-1:0]    i_rd_tuse;
  logic [NRD*DW-1:0]    i_rd_val;
  logic [NRD*DW-1:0]    o_rd_val;
  logic [NRD*SW-1:0]    o_rd_sel;
  logic [NRD-1:0]       o_rd_pend;
  logic                 o_stall;
  logic [31:0]          o_stall_cnt;

  fwd_bypass_net #(
    .NSTAGE(NSTAGE), .NRD(NRD), .DW(DW), .AW(AW), .TW(TW), .SW(SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_freeze     (i_freeze),
    .i_issue_valid(i_issue_valid),
    .i_issue_addr (i_issue_addr),
    .i_issue_tnew (i_issue_tnew),
    .i_stage_data (i_stage_data),
    .i_rd_addr    (i_rd_addr),
    .i_rd_tuse    (i_rd_tuse),
    .i_rd_val     (i_rd_val),
    .o_rd_val     (o_rd_val),
    .o_rd_sel     (o_rd_sel),
    .o_rd_pend    (o_rd_pend),
    .o_stall      (o_stall),
    .o_stall_cnt  (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ia;
    logic [1:0]  it;
    logic        fz;
    logic [4:0]  a0;
    logic [1:0]  u0;
    logic [4:0]  a1;
    logic [1:0]  u1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  es0;
    logic [1:0]  es1;
    logic [1:0]  ep;
    logic        est;
    logic [31:0] ev0;
    logic [31:0] ev1;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reset for two cycles while an issue is offered, then confirm an empty
  // scoreboard with a port reading the register that was offered.
  task automatic reset_seq(input string tag);
    @(negedge clk);
    reset         = 1'b1;
    i_freeze      = 1'b0;
    i_issue_valid = 1'b1;
    i_issue_addr  = 5'd9;
    i_issue_tnew  = 2'd3;
    i_rd_addr     = {5'd9, 5'd9};
    i_rd_tuse     = {2'd0, 2'd0};
    i_stage_data  = {D2, D1, D0};
    i_rd_val      = {RV1, RV0};
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    chk({tag, "_sel"},   32'(o_rd_sel), 32'd0);
    chk({tag, "_pend"},  32'(o_rd_pend), 32'd0);
    chk({tag, "_val0"},  o_rd_val[31:0], RV0);
    chk({tag, "_val1"},  o_rd_val[63:32], RV1);
    chk({tag, "_cnt"},   o_stall_cnt, 32'd0);
    i_issue_valid = 1'b0;
    i_rd_addr     = '0;
  endtask

  initial begin
    reset         = 1'b1;
    i_freeze      = 1'b0;
    i_issue_valid = 1'b0;
    i_issue_addr  = '0;
    i_issue_tnew  = '0;
    i_stage_data  = '0;
    i_rd_addr     = '0;
    i_rd_tuse     = '0;
    i_rd_val      = '0;

    // iv ia it fz | a0 u0 a1 u1 | d0 d1 d2 | sel0 sel1 pend stall val0 val1 cnt
    // E->D forward, both ports on the same register
    vecs.push_back('{1, 8, 0, 0, 8, 0, 0, 0, D0, D1, D2, 0, 0, 0, 0, RV0, RV1, 0});
    vecs.push_back('{0, 0, 0, 0, 8, 0, 8, 3, 32'h1234, D1, D2, 1, 1, 0, 0, 32'h1234, 32'h1234, 0});
    // load-use: issue 5 tnew 2 (8 is now in M)
    vecs.push_back('{1, 5, 2, 0, 8, 0, 0, 0, D0, D1, D2, 2, 0, 0, 0, D1, RV1, 0});
    vecs.push_back('{1, 6, 0, 0, 5, 0, 8, 0, D0, D1, D2, 0, 3, 1, 1, RV0, D2, 0});
    vecs.push_back('{1, 6, 0, 0, 5, 0, 6, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 1});
    vecs.push_back('{1, 6, 0, 0, 5, 0, 6, 0, D0, D1, D2, 3, 0, 0, 0, D2, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 5, 0, 6, 0, D0, D1, D2, 0, 1, 0, 0, RV0, D0, 2});
    // youngest wins
    vecs.push_back('{1, 3, 0, 0, 0, 0, 0, 0, D0, D1, D2, 0, 0, 0, 0, RV0, RV1, 2});
    vecs.push_back('{1, 3, 0, 0, 3, 0, 0, 0, 32'hA, D1, D2, 1, 0, 0, 0, 32'hA, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 3, 0, 3, 2, 32'hB, 32'hA, D2, 1, 1, 0, 0, 32'hB, 32'hB, 2});
    // issue to $0 and read of $0
    vecs.push_back('{1, 0, 3, 0, 0, 0, 3, 0, D0, D1, D2, 0, 2, 0, 0, RV0, D1, 2});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 3, 0, D0, D1, D2, 0, 3, 0, 0, RV0, D2, 2});
    // pend without stall
    vecs.push_back('{1, 7, 1, 0, 0, 0, 0, 0, D0, D1, D2, 0, 0, 0, 0, RV0, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 7, 1, 7, 2, D0, D1, D2, 0, 0, 3, 0, RV0, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 7, 0, 0, 0, D0, D1, D2, 2, 0, 0, 0, D1, RV1, 2});
    // freeze with a stalling entry (9, tnew 3) in E; issue of 4 must be ignored
    vecs.push_back('{1, 9, 3, 0, 0, 0, 0, 0, D0, D1, D2, 0, 0, 0, 0, RV0, RV1, 2});
    vecs.push_back('{1, 4, 0, 1, 9, 0, 4, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 2});
    vecs.push_back('{1, 4, 0, 1, 9, 0, 4, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 2});
    vecs.push_back('{1, 4, 0, 1, 9, 0, 4, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 9, 0, 4, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 2});
    vecs.push_back('{0, 0, 0, 0, 9, 1, 4, 0, D0, D1, D2, 0, 0, 1, 1, RV0, RV1, 3});
    vecs.push_back('{0, 0, 0, 0, 9, 1, 4, 0, D0, D1, D2, 0, 0, 1, 0, RV0, RV1, 4});
    vecs.push_back('{0, 0, 0, 0, 9, 0, 4, 0, D0, D1, D2, 0, 0, 0, 0, RV0, RV1, 4});

    reset_seq("rst0");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      i_issue_valid = vecs[i].iv;
      i_issue_addr  = vecs[i].ia;
      i_issue_tnew  = vecs[i].it;
      i_freeze      = vecs[i].fz;
      i_rd_addr     = {vecs[i].a1, vecs[i].a0};
      i_rd_tuse     = {vecs[i].u1, vecs[i].u0};
      i_stage_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      i_rd_val      = {RV1, RV0};
      #1;
      chk($sformatf("v%0d_sel0", i),  32'(o_rd_sel[1:0]), 32'(vecs[i].es0));
      chk($sformatf("v%0d_sel1", i),  32'(o_rd_sel[3:2]), 32'(vecs[i].es1));
      chk($sformatf("v%0d_pend", i),  32'(o_rd_pend), 32'(vecs[i].ep));
      chk($sformatf("v%0d_stall", i), 32'(o_stall), 32'(vecs[i].est));
      chk($sformatf("v%0d_val0", i),  o_rd_val[31:0], vecs[i].ev0);
      chk($sformatf("v%0d_val1", i),  o_rd_val[63:32], vecs[i].ev1);
      chk($sformatf("v%0d_cnt", i),   o_stall_cnt, vecs[i].ecnt);
    end

    // Reset with a non-zero counter must clear it and the scoreboard.
    reset_seq("rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
